// File: rtl/ibuf_sram_writer.sv
// Write-side sequencer for the 3-bank input-buffer SRAM: packs two picture lines per bank.
// Optional zero-padding column insertion is built only when IBUF_PAD_INSERT_EN is defined.
module ibuf_sram_writer #(
  parameter int AW    = 10,
  parameter int DW    = 128,
  parameter int NBANK = 3
) (
  input  logic            SYS_CLK,
  input  logic            SYS_NRST,
  input  logic            frame_start_i,
  input  logic [5:0]      pic_size_i,
  input  logic            padding_i,
  input  logic [DW-1:0]   in_data_i,
  input  logic            in_vld_i,
  output logic            in_rdy_o,
  input  logic            bank_release_i,
  output logic            wsram_start_o,
  output logic            wsram_2line_o,
  output logic [DW-1:0]   wdata_o,
  output logic            wdata_vld_o,
  output logic [AW+1:0]   waddr_o,
  output logic            frame_done_o,
  output logic            busy_o
);

  typedef enum logic [1:0] {IDLE, START, WRITE, DONE} state_e;

  localparam logic [1:0] CreditMax = 2'(NBANK);
  localparam logic [1:0] LastBank  = 2'(NBANK - 1);

  state_e          state_q;
  logic [5:0]      pic_q;
  logic [6:0]      linelen_q;
  logic [6:0]      col_q;
  logic [6:0]      lbase_q;
  logic [5:0]      row_q;
  logic            lb_q;
  logic [1:0]      bank_q;
  logic [1:0]      credit_q, credit_d;
  logic [DW-1:0]   wdata_q;
  logic [AW+1:0]   waddr_q;
  logic            wvld_q, w2line_q, wstart_q, fdone_q;

  logic line_end, last_row, take, close, pad_slot;

  assign line_end = (col_q == linelen_q - 7'd1);
  assign last_row = (row_q == pic_q - 6'd1);

`ifdef IBUF_PAD_INSERT_EN
  logic pad_q;
  assign pad_slot = pad_q & ((col_q == 7'd0) | line_end);
`else
  logic unused_padding;
  assign pad_slot       = 1'b0;
  assign unused_padding = padding_i;
`endif

  // A word is written when a credit is available and either an input beat or a pad slot is due.
  assign in_rdy_o = (state_q == WRITE) && (credit_q != 2'd0) && !pad_slot;
  assign take     = (state_q == WRITE) && (credit_q != 2'd0) && (pad_slot || in_vld_i);
  assign close    = take && line_end && (lb_q || last_row);

  assign wsram_start_o = wstart_q;
  assign wsram_2line_o = w2line_q;
  assign wdata_o       = wdata_q;
  assign wdata_vld_o   = wvld_q;
  assign waddr_o       = waddr_q;
  assign frame_done_o  = fdone_q;
  assign busy_o        = (state_q != IDLE);

  // A bank close and a release in the same cycle cancel out; releases saturate at NBANK.
  always_comb begin
    credit_d = credit_q;
    if (close && !bank_release_i) begin
      credit_d = credit_q - 2'd1;
    end else if (!close && bank_release_i && credit_q != CreditMax) begin
      credit_d = credit_q + 2'd1;
    end
  end

  always_ff @(posedge SYS_CLK or negedge SYS_NRST) begin
    if (!SYS_NRST) begin
      state_q   <= IDLE;
      pic_q     <= '0;
      linelen_q <= '0;
      col_q     <= '0;
      lbase_q   <= '0;
      row_q     <= '0;
      lb_q      <= 1'b0;
      bank_q    <= '0;
      credit_q  <= CreditMax;
      wdata_q   <= '0;
      waddr_q   <= '0;
      wvld_q    <= 1'b0;
      w2line_q  <= 1'b0;
      wstart_q  <= 1'b0;
      fdone_q   <= 1'b0;
`ifdef IBUF_PAD_INSERT_EN
      pad_q     <= 1'b0;
`endif
    end else begin
      credit_q <= credit_d;
      wstart_q <= 1'b0;
      fdone_q  <= 1'b0;
      wvld_q   <= take;
      w2line_q <= close;
      if (take) begin
        wdata_q <= pad_slot ? '0 : in_data_i;
        waddr_q <= {bank_q, AW'(lbase_q) + AW'(col_q)};
      end
      case (state_q)
        IDLE: begin
          if (frame_start_i && pic_size_i != 6'd0) begin
            pic_q    <= pic_size_i;
            col_q    <= '0;
            lbase_q  <= '0;
            row_q    <= '0;
            lb_q     <= 1'b0;
            wstart_q <= 1'b0 | 1'b1;
            state_q  <= START;
`ifdef IBUF_PAD_INSERT_EN
            pad_q     <= padding_i;
            linelen_q <= padding_i ? {1'b0, pic_size_i} + 7'd2 : {1'b0, pic_size_i};
`else
            linelen_q <= {1'b0, pic_size_i};
`endif
          end
        end
        START: state_q <= WRITE;
        WRITE: begin
          if (take) begin
            if (line_end) begin
              col_q <= '0;
              row_q <= row_q + 6'd1;
              if (close) begin
                lb_q    <= 1'b0;
                lbase_q <= '0;
                bank_q  <= (bank_q == LastBank) ? 2'd0 : bank_q + 2'd1;
              end else begin
                lb_q    <= 1'b1;
                lbase_q <= linelen_q;
              end
              if (last_row) state_q <= DONE;
            end else begin
              col_q <= col_q + 7'd1;
            end
          end
        end
        DONE: begin
          fdone_q <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
